dmem_resp: RTL and testbench
============================

// Module: dmem_resp
// PURPOSE
//  Data-memory responder: the memory-side end of the mem-stage load/store path.
//  Accepts one request at a time over a valid/ready handshake and models LATENCY wait states.
//  Performs RV32I byte/half/word stores and sign/zero-extended loads on an internal word array.
//  Returns data or an error over a valid/ready response channel.
//  Sits between the mem stage (ex_mem_reg outputs) and the mem_wb_reg inputs.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the array (byte address range 0..4*DEPTH_WORDS-1)
//  LATENCY      2     wait cycles between accept and response; legal range 0..15
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_addr   in   32  byte address
//  req_we     in   1   1=store, 0=load
//  req_func3  in   3   RV32I funct3: 0=B 1=H 2=W 4=BU 5=HU (BU/HU are loads only)
//  req_wdata  in   32  store data; low byte/half used for SB/SH
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer takes response
//  rsp_rdata  out  32  load result (extended); 0 for stores and errors
//  rsp_err    out  1   request was misaligned, out of range, or had illegal func3
//  busy       out  1   high in WAIT or RESP
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//   - The array is not reset.
//   - Reset mid-request aborts the request; a store is not written unless already committed.
//  FSM:
//   - IDLE: if req_valid, latch addr/we/func3/wdata.
//     Go to WAIT if LATENCY>0 (counter=LATENCY-1); otherwise go to RESP.
//   - WAIT: decrement the counter; go to RESP on the edge where counter==0.
//   - RESP: rsp_valid=1; if rsp_ready, go to IDLE.
//     No same-cycle re-accept, so back-to-back throughput is one request per LATENCY+2 cycles.
//  Latency:
//   - Request accepted at edge N; rsp_valid is high from cycle N+1+LATENCY.
//   - Response outputs are registered and stay stable until the rsp handshake.
//   - rsp_rdata and rsp_err are cleared on leaving RESP.
//  Error check (on latched fields):
//   - H/HU with addr[0]!=0.
//   - W with addr[1:0]!=0.
//   - func3 in {3,6,7}.
//   - Store with func3 in {4,5}.
//   - addr[31:2] >= DEPTH_WORDS.
//   - On error: rsp_err=1, rsp_rdata=0, no array write.
//  Commit: a store writes the array on the edge that enters RESP; only the byte lanes selected by addr[1:0] change.
//  Loads:
//   - The word is read on the edge entering RESP.
//   - The lane is selected by addr[1:0]; B/H are sign-extended, BU/HU zero-extended.
//  Inputs other than req_valid are don't-care outside IDLE; latched values are never re-sampled.
//  rsp_ready asserted with rsp_valid low has no effect.
// TESTING
//  1. Hold rst_n=0 -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//  2. SW 0xDEADBEEF @0x10, then LW/LB/LBU/LHU:
//     LW @0x10 -> 0xDEADBEEF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LHU @0x12 -> 0x0000DEAD.
//  3. SW 0 @0x20, SH 0x1234 @0x22, SB 0x55 @0x20, then LW @0x20 -> 0x12340055, err=0.
//  4. LW @0x11 and SH @0x21 -> rsp_err=1, rdata=0; LW @0x20 still reads 0x12340055.
//     LW @4*DEPTH_WORDS -> err=1.
//  5. LATENCY=0 and LATENCY=3: accept at edge N -> rsp_valid at N+1 and N+4 respectively.
//     With rsp_ready held low 5 cycles: rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
//  6. SW 0xCAFEF00D @0x30, then assert rst_n=0 during WAIT (LATENCY=3):
//     a later LW @0x30 returns the pre-test value; all outputs return to reset values immediately.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder for the load/store path. It serves one RV32I load or store at a time from an internal word array.
// Latency: LATENCY wait cycles; rsp_valid rises LATENCY edges after the accept edge, so there is one request per LATENCY+2 cycles.
// Backpressure: req_ready is high only when idle; the response is held registered and stable until rsp_ready.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // The array is not reset. Its contents survive a reset.
  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=0 the commit happens on the accept edge. The operation therefore
  // comes straight from the request pins while idle, and from the latched copy otherwise.
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_we;
  logic [2:0]  op_func3;
  logic        op_err;
  logic [AW-1:0] op_idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        go_resp;
  logic        commit;

  // Select the operation source: live request when idle, latched fields after acceptance.
  always_comb begin
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_we    = we_q;
    op_func3 = func3_q;
    if (state_q == ST_IDLE) begin
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_we    = req_we;
      op_func3 = req_func3;
    end
  end

  assign op_idx = op_addr[AW+1:2];

  // Flag misaligned accesses, illegal func3 codes, unsigned stores and out-of-range words.
  always_comb begin
    op_err = 1'b0;
    case (op_func3)
      F3_B, F3_BU: op_err = 1'b0;
      F3_H, F3_HU: op_err = op_addr[0];
      F3_W:        op_err = |op_addr[1:0];
      default:     op_err = 1'b1;
    endcase
    if (op_we && (op_func3 == F3_BU || op_func3 == F3_HU)) begin
      op_err = 1'b1;
    end
    if ({2'b00, op_addr[31:2]} >= DEPTH_L) begin
      op_err = 1'b1;
    end
  end

  // Select the load lane from addr[1:0] and extend the result to 32 bits.
  always_comb begin
    rd_word = mem[op_idx];
    rd_byte = rd_word[7:0];
    case (op_addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_func3)
      F3_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    ld_data = {{16{rd_half[15]}}, rd_half};
      F3_W:    ld_data = rd_word;
      F3_BU:   ld_data = {24'd0, rd_byte};
      F3_HU:   ld_data = {16'd0, rd_half};
      default: ld_data = 32'd0;
    endcase
  end

  // Build the store byte enables and the lane-replicated store data.
  always_comb begin
    st_be   = 4'b0000;
    st_data = op_wdata;
    case (op_func3)
      F3_B: begin
        st_be   = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      F3_H: begin
        st_be   = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      F3_W: begin
        st_be   = 4'b1111;
        st_data = op_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = op_wdata;
      end
    endcase
  end

  // Compute the next state and counter, latch the request, and form the registered response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    func3_d     = func3_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    go_resp     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          func3_d = req_func3;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (go_resp) begin
      rsp_err_d   = op_err;
      rsp_rdata_d = (op_err || op_we) ? 32'd0 : ld_data;
    end
  end

  // Commit a store only while out of reset, so an aborted request never writes the array.
  assign commit = go_resp && op_we && !op_err && rst_n;

  // Register the control state and the response; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      func3_q     <= 3'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // On the store commit edge, write only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[op_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Testbench for dmem_resp. Two instances are checked: index 0 has LATENCY=3 and 1024 words; index 1 has LATENCY=0 and 16 words.
// Every request pushes its expected response into a per-instance queue, and a monitor pops and compares on each response handshake.
// The stimulus task also checks accept-to-valid latency and that the response holds steady while stalled.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][2:0]  req_func3;

  int errors = 0;
  int checks = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_we(req_we[0]), .req_func3(req_func3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_resp #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_we(req_we[1]), .req_func3(req_func3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for instance 0 (LATENCY=3).
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp0: got rsp_valid=1 expected no response");
      end else begin
        e = q0.pop_front();
        check("rsp_rdata0", rsp_rdata[0], e[31:0]);
        check("rsp_err0", {31'd0, rsp_err[0]}, {31'd0, e[32]});
      end
    end
  end

  // Monitor for instance 1 (LATENCY=0).
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp1: got rsp_valid=1 expected no response");
      end else begin
        e = q1.pop_front();
        check("rsp_rdata1", rsp_rdata[1], e[31:0]);
        check("rsp_err1", {31'd0, rsp_err[1]}, {31'd0, e[32]});
      end
    end
  end

  // Issue one request to instance d, queue its expected response, and wait for the handshake.
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int n;
    int qs;
    if (d == 0) q0.push_back({exp_err, exp_rd});
    else        q1.push_back({exp_err, exp_rd});
    req_we[d]    = we;
    req_func3[d] = f3;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    rsp_ready[d] = (stall == 0);
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, (d == 0) ? 32'd3 : 32'd0);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", {31'd0, rsp_valid[d]}, 32'd1);
        check("stall_rdata", rsp_rdata[d], exp_rd);
        check("stall_err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
        check("stall_req_ready", {31'd0, req_ready[d]}, 32'd0);
      end
      rsp_ready[d] = 1'b1;
    end
    n = 0;
    qs = (d == 0) ? q0.size() : q1.size();
    while (qs != 0 && n < 30) begin
      @(posedge clk); #1; n++;
      qs = (d == 0) ? q0.size() : q1.size();
    end
    if (qs != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no response handshake expected one");
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
    check("rst_busy", {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_func3 = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outputs(d);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store, then loads of each width and signedness (LATENCY=3).
    do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0,       32'hDEADBEEF, 1'b0, 0);
    do_req(0, 1'b0, 3'd0, 32'h13, 32'h0,       32'hFFFFFFDE, 1'b0, 0);
    do_req(0, 1'b0, 3'd4, 32'h13, 32'h0,       32'h000000DE, 1'b0, 0);
    do_req(0, 1'b0, 3'd5, 32'h12, 32'h0,       32'h0000DEAD, 1'b0, 0);
    do_req(0, 1'b0, 3'd1, 32'h10, 32'h0,       32'hFFFFBEEF, 1'b0, 0);
    do_req(0, 1'b0, 3'd0, 32'h10, 32'h0,       32'hFFFFFFEF, 1'b0, 0);

    // Partial-lane stores merge into one word.
    do_req(0, 1'b1, 3'd2, 32'h20, 32'h00000000, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 3'd1, 32'h22, 32'hAAAA1234, 32'h0, 1'b0, 0);
    do_req(0, 1'b1, 3'd0, 32'h20, 32'hFFFFFF55, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h12340055, 1'b0, 0);

    // Error cases leave the array untouched.
    do_req(0, 1'b0, 3'd2, 32'h11,   32'h0,        32'h0, 1'b1, 0);
    do_req(0, 1'b1, 3'd1, 32'h21,   32'hFFFFFFFF, 32'h0, 1'b1, 0);
    do_req(0, 1'b1, 3'd4, 32'h20,   32'hFFFFFFFF, 32'h0, 1'b1, 0);
    do_req(0, 1'b0, 3'd3, 32'h20,   32'h0,        32'h0, 1'b1, 0);
    do_req(0, 1'b0, 3'd2, 32'h1000, 32'h0,        32'h0, 1'b1, 0);
    do_req(0, 1'b0, 3'd2, 32'h20,   32'h0, 32'h12340055, 1'b0, 0);

    // Response held under backpressure for 5 cycles.
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // Zero-latency instance: last word, range edge, and stall.
    do_req(1, 1'b1, 3'd2, 32'h3C, 32'h80C3A57E, 32'h0,        1'b0, 0);
    do_req(1, 1'b0, 3'd5, 32'h3E, 32'h0,        32'h000080C3, 1'b0, 0);
    do_req(1, 1'b0, 3'd1, 32'h3E, 32'h0,        32'hFFFF80C3, 1'b0, 0);
    do_req(1, 1'b0, 3'd0, 32'h3D, 32'h0,        32'hFFFFFFA5, 1'b0, 0);
    do_req(1, 1'b0, 3'd2, 32'h40, 32'h0,        32'h0,        1'b1, 0);
    do_req(1, 1'b0, 3'd4, 32'h3C, 32'h0,        32'h0000007E, 1'b0, 5);

    // Reset during WAIT aborts a pending store.
    do_req(0, 1'b1, 3'd2, 32'h30, 32'h11112222, 32'h0, 1'b0, 0);
    req_we[0]    = 1'b1;
    req_func3[0] = 3'd2;
    req_addr[0]  = 32'h30;
    req_wdata[0] = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("wait_busy", {31'd0, busy[0]}, 32'd1);
    check("wait_req_ready", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    do_req(0, 1'b0, 3'd2, 32'h30, 32'h0, 32'h11112222, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
